// File: rtl/dmem_responder.sv
// dmem_responder -- data-memory responder for the MEM-stage data interface.
//
// Accepts word-address reads and sized, possibly unaligned, big-endian
// byte-lane writes. Each access is serviced after LATENCY busy cycles while
// mem_stall holds the pipeline, then mem_ack pulses for one cycle. Reads
// return the full aligned word; lane extraction is left to the MEM stage.
//
// Optional feature macro: DMEM_POSTED_WRITE_EN
//   defined   : writes commit in IDLE at the accepting edge with no stall,
//               mem_ack/size_err pulse the following cycle, state stays IDLE.
//   undefined : writes take the same IDLE/BUSY/DONE path as reads.
//
// Ports:
//   CLK                  clock, all state changes on the rising edge
//   RESET                synchronous active-high reset
//   data_address_2DM     byte address (word index = [ADDR_BITS+1:2])
//   data_write_2DM       store data, right-justified
//   data_write_size_2DM  byte count: 0=4, 1=1, 2=2, 3=3
//   MemRead_2DM          read request (level)
//   MemWrite_2DM         write request (level), wins over MemRead_2DM
//   data_read_fDM        registered read word
//   mem_stall            pipeline must hold its request
//   mem_ack              one-cycle completion pulse
//   size_err             pulses with mem_ack when write bytes pass offset 3

module dmem_responder #(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] data_address_2DM,
  input  logic [31:0] data_write_2DM,
  input  logic [1:0]  data_write_size_2DM,
  input  logic        MemRead_2DM,
  input  logic        MemWrite_2DM,
  output logic [31:0] data_read_fDM,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        size_err
);

`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  // State and captured request
  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [1:0]           off_q, off_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [1:0]           size_q, size_d;
  logic                 is_wr_q, is_wr_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [31:0]          rdata_q;

  // Storage; contents survive reset
  logic [31:0] mem_array [2**ADDR_BITS];

  // Byte-lane plan for the write being committed
  logic [ADDR_BITS-1:0] src_idx;
  logic [1:0]           src_off;
  logic [1:0]           src_size;
  logic [31:0]          src_data;
  logic [2:0]           n_bytes;
  logic                 lane_err;
  logic [3:0]           lane_be;      // index = byte offset, 0 is bits [31:24]
  logic [3:0][7:0]      lane_byte;
  logic [2:0]           k_v;
  logic [5:0]           sh_v;
  logic [31:0]          shifted_v;

  logic wr_en;
  logic rd_en;

  logic unused_addr;
  assign unused_addr = ^data_address_2DM[31:ADDR_BITS+2];

  // In IDLE only a posted write commits, and it uses the live inputs;
  // elsewhere the captured request is the source.
  always_comb begin
    if (state_q == S_IDLE) begin
      src_idx  = data_address_2DM[ADDR_BITS+1:2];
      src_off  = data_address_2DM[1:0];
      src_size = data_write_size_2DM;
      src_data = data_write_2DM;
    end else begin
      src_idx  = idx_q;
      src_off  = off_q;
      src_size = size_q;
      src_data = wdata_q;
    end

    n_bytes   = (src_size == 2'd0) ? 3'd4 : {1'b0, src_size};
    lane_err  = ({1'b0, src_off} + n_bytes) > 3'd4;
    lane_be   = '0;
    lane_byte = '0;
    k_v       = '0;
    sh_v      = '0;
    shifted_v = '0;
    // Offset o receives byte k = o - a, taken from data[8(n-k)-1 -: 8].
    // Bytes whose offset would exceed 3 simply have no lane to land in.
    for (int o = 0; o < 4; o++) begin
      k_v          = 3'(o) - {1'b0, src_off};
      lane_be[o]   = (3'(o) >= {1'b0, src_off}) && (k_v < n_bytes);
      sh_v         = {3'(n_bytes - 3'd1 - k_v), 3'b000};
      shifted_v    = src_data >> sh_v;
      lane_byte[o] = shifted_v[7:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    is_wr_d   = is_wr_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    mem_stall = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (POSTED && MemWrite_2DM) begin
          wr_en = 1'b1;
          ack_d = 1'b1;
          err_d = lane_err;
        end else if (MemRead_2DM || MemWrite_2DM) begin
          mem_stall = 1'b1;
          idx_d     = data_address_2DM[ADDR_BITS+1:2];
          off_d     = data_address_2DM[1:0];
          wdata_d   = data_write_2DM;
          size_d    = data_write_size_2DM;
          is_wr_d   = MemWrite_2DM;
          cnt_d     = CNT_LOAD;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        mem_stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          ack_d   = 1'b1;
          if (is_wr_q) begin
            wr_en = 1'b1;
            err_d = lane_err;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      S_DONE: begin
        // Request inputs still belong to the completing instruction.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      is_wr_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      is_wr_q <= is_wr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Byte-enabled write port; RESET on the committing edge aborts the write.
  always_ff @(posedge CLK) begin
    if (wr_en && !RESET) begin
      for (int o = 0; o < 4; o++) begin
        if (lane_be[o]) begin
          mem_array[src_idx][8*(3-o) +: 8] <= lane_byte[o];
        end
      end
    end
  end

  // Registered read port; holds until the next completed read.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem_array[idx_q];
    end
  end

  assign data_read_fDM = rdata_q;
  assign mem_ack       = ack_q;
  assign size_err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- scoreboard bench for dmem_responder.
// Expected read words / size_err are pushed when a request is driven and
// popped when mem_ack is seen. A word-level memory model applies the
// big-endian byte-lane rules independently of the design.
`timescale 1ns/1ps

module tb_dmem_responder;

  localparam int LAT = 2;
  localparam int AB  = 10;

`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  wsize = '0;
  logic        mrd = 1'b0;
  logic        mwr = 1'b0;
  logic [31:0] rdata;
  logic        stall;
  logic        ack;
  logic        serr;

  dmem_responder #(.LATENCY(LAT), .ADDR_BITS(AB)) dut (
    .CLK                 (clk),
    .RESET               (rst),
    .data_address_2DM    (addr),
    .data_write_2DM      (wdata),
    .data_write_size_2DM (wsize),
    .MemRead_2DM         (mrd),
    .MemWrite_2DM        (mwr),
    .data_read_fDM       (rdata),
    .mem_stall           (stall),
    .mem_ack             (ack),
    .size_err            (serr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  logic [31:0] last_rd = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int key_of(input logic [31:0] a);
    return int'(a[AB+1:2]);
  endfunction

  // Reference merge: byte k of the right-justified data lands at offset a+k.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [1:0] sz,
                                        output bit err);
    logic [31:0] res;
    int n, off;
    res = old;
    err = 1'b0;
    n   = (sz == 2'd0) ? 4 : int'(sz);
    for (int k = 0; k < n; k++) begin
      off = int'(a[1:0]) + k;
      if (off <= 3) res[31-8*off -: 8] = d[8*(n-k)-1 -: 8];
      else          err = 1'b1;
    end
    return res;
  endfunction

  // Scoreboard side: one pop per acknowledged access.
  always @(negedge clk) begin
    if (!rst) begin
      if (ack) begin
        if (sb.size() == 0) begin
          chk("spurious_ack", {31'b0, ack}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(e.is_rd ? "rd_data" : "wr_keeps_rd", rdata, e.data);
          chk("size_err", {31'b0, serr}, {31'b0, e.err});
        end
      end else begin
        chk("size_err_idle", {31'b0, serr}, 32'h0);
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; mrd = 1'b0; mwr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    last_rd = '0;
  endtask

  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input string tag);
    exp_t        e;
    logic [31:0] old;
    bit          err;
    int          stalls, cyc, exp_cyc, exp_stalls;
    int          key;
    key = key_of(a);
    @(posedge clk); #1;
    if (wr) begin
      old        = model.exists(key) ? model[key] : 32'h0;
      model[key] = merge(old, a, d, sz, err);
      e          = '{1'b0, last_rd, err};
    end else begin
      last_rd = model.exists(key) ? model[key] : 32'h0;
      e       = '{1'b1, last_rd, 1'b0};
    end
    sb.push_back(e);
    addr = a; wdata = d; wsize = sz; mwr = wr; mrd = !wr;
    exp_cyc    = (POSTED && wr) ? 1 : LAT + 1;
    exp_stalls = (POSTED && wr) ? 0 : LAT + 1;
    stalls = 0; cyc = 0;
    @(negedge clk);
    while (!ack && cyc < 40) begin
      if (stall) stalls++;
      cyc++;
      @(negedge clk);
    end
    mrd = 1'b0; mwr = 1'b0;
    chk({tag, "_ack_cycle"}, cyc, exp_cyc);
    chk({tag, "_stall_cycles"}, stalls, exp_stalls);
    @(negedge clk);
    chk({tag, "_ack_one_cycle"}, {31'b0, ack}, 32'h0);
    $display("txn %-10s %s addr=%h data=%h size=%0d rd=%h", tag, wr ? "WR" : "RD", a, d, sz, rdata);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_serr", {31'b0, serr}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);

    // Read after reset keeps preloaded contents
    txn(1, 32'h10, 32'h11223344, 2'd0, "preload10");
    reset_dut();
    txn(0, 32'h10, 32'h0, 2'd0, "rd10");

    // Single byte into a word of ones
    txn(1, 32'h20, 32'hFFFFFFFF, 2'd0, "fill20");
    txn(1, 32'h21, 32'h000000AB, 2'd1, "byte21");
    txn(0, 32'h20, 32'h0, 2'd0, "rd20");

    // Halfword at offset 2, then 3 bytes aligned
    txn(1, 32'h30, 32'h0, 2'd0, "clr30");
    txn(1, 32'h32, 32'h0000BEEF, 2'd2, "half32");
    txn(0, 32'h30, 32'h0, 2'd0, "rd30a");
    txn(1, 32'h30, 32'h00123456, 2'd3, "swr30");
    txn(0, 32'h30, 32'h0, 2'd0, "rd30b");

    // Overflow past offset 3: dropped byte, size_err, next word intact
    txn(1, 32'h40, 32'h0, 2'd0, "clr40");
    txn(1, 32'h44, 32'hA5A5A5A5, 2'd0, "fill44");
    txn(1, 32'h43, 32'h0000CAFE, 2'd2, "ovf43");
    txn(0, 32'h40, 32'h0, 2'd0, "rd40");
    txn(0, 32'h44, 32'h0, 2'd0, "rd44");

    // SWL-style fill of offsets 1..3, then wrapped index read
    txn(1, 32'h70, 32'h0, 2'd0, "clr70");
    txn(1, 32'h71, 32'h00ABCDEF, 2'd3, "swl71");
    txn(0, 32'h1070, 32'h0, 2'd0, "rdwrap70");

`ifndef DMEM_POSTED_WRITE_EN
    // RESET in the second BUSY cycle aborts the write
    txn(1, 32'h50, 32'h01020304, 2'd0, "pre50");
    @(posedge clk); #1;
    addr = 32'h50; wdata = 32'hDEADBEEF; wsize = 2'd0; mwr = 1'b1;
    @(negedge clk);
    chk("abort_stall_c0", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mwr = 1'b0;
    @(negedge clk);
    chk("abort_no_ack_c2", {31'b0, ack}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
    @(negedge clk);
    chk("abort_stall_c3", {31'b0, stall}, 32'h0);
    chk("abort_no_ack_c3", {31'b0, ack}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    chk("abort_no_ack_c4", {31'b0, ack}, 32'h0);
    $display("txn abort50   WR addr=00000050 data=deadbeef reset in BUSY");
    txn(0, 32'h50, 32'h0, 2'd0, "rd50");
`else
    // Posted write followed immediately by a read of the same word
    begin
      exp_t e;
      bit   err;
      int   stalls;
      @(posedge clk); #1;
      model[key_of(32'h60)] = merge(32'h0, 32'h60, 32'h12345678, 2'd0, err);
      e = '{1'b0, last_rd, err};
      sb.push_back(e);
      addr = 32'h60; wdata = 32'h12345678; wsize = 2'd0; mwr = 1'b1;
      @(negedge clk);
      chk("posted_no_stall", {31'b0, stall}, 32'h0);
      @(posedge clk); #1;
      mwr = 1'b0; mrd = 1'b1;
      last_rd = model[key_of(32'h60)];
      e = '{1'b1, last_rd, 1'b0};
      sb.push_back(e);
      stalls = 0;
      for (int c = 0; c <= LAT; c++) begin
        @(negedge clk);
        if (stall) stalls++;
      end
      chk("posted_rd_stalls", stalls, LAT + 1);
      @(negedge clk);
      chk("posted_rd_ack", {31'b0, ack}, 32'h1);
      mrd = 1'b0;
      @(negedge clk);
      $display("txn posted60  WR+RD addr=00000060 rd=%h", rdata);
    end
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the MEM-stage data interface.
- Accepts word-address reads and sized, possibly unaligned, byte-lane writes.
- Services each request after a programmable latency while stalling the pipeline.
- Reads return the full aligned big-endian word; the MEM stage does lane extraction and sign extension.

Parameters:
- LATENCY, 2: BUSY cycles before the access is performed; legal range 1..15.
- ADDR_BITS, 10: word-index width; the array holds 2^ADDR_BITS 32-bit words.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- data_address_2DM  in  32  byte address. Aligned for reads; may be unaligned for writes.
- data_write_2DM  in  32  store data, right-justified in the low bytes.
- data_write_size_2DM  in  2  byte count: 0=4 bytes, 1=1, 2=2, 3=3.
- MemRead_2DM  in  1  read request (level).
- MemWrite_2DM  in  1  write request (level); wins if both request inputs are high.
- data_read_fDM  out  32  registered read word.
- mem_stall  out  1  pipeline must hold its request.
- mem_ack  out  1  one-cycle pulse when the access has completed.
- size_err  out  1  one-cycle pulse with mem_ack when write bytes fall past offset 3.

Behaviour:
- Reset values: state IDLE, data_read_fDM=0, mem_ack=0, size_err=0, counter=0.
  - Array contents are not cleared by reset.
- Word index = address[ADDR_BITS+1:2]. Higher address bits are ignored, so the index wraps.
- Big-endian: byte offset 0 is bits [31:24].
- FSM states: IDLE, BUSY, DONE.
  - IDLE: when MemRead_2DM or MemWrite_2DM is high, capture address, data, size and op. Load counter=LATENCY-1 and go to BUSY. mem_stall is asserted combinationally in this cycle.
  - BUSY: mem_stall=1. While counter!=0, decrement it. When counter==0, perform the access at this edge and go to DONE.
  - DONE: mem_stall=0 and mem_ack=1 for exactly one cycle. Request inputs are ignored (they still belong to the completing instruction). Next state is IDLE.
- Timing: a request first seen in cycle 0 holds mem_stall high for cycles 0..LATENCY; mem_ack is high in cycle LATENCY+1.
- Read: data_read_fDM <= array[index]. It holds its value until the next read completes; writes never change it.
- Write, with n = byte count and a = address[1:0]:
  - For k=0..n-1, byte data_write_2DM[8(n-k)-1 -: 8] goes to offset a+k, provided a+k<=3.
  - Bytes with a+k>3 are dropped, never carried into the next word, and size_err pulses in DONE.
  - Untouched bytes of the word are preserved.
- Write mapping checks:
  - size 0 with a=0 is a full-word store.
  - size 1 writes data[7:0] at offset a.
  - SWR-style (aligned, size n) fills offsets 0..n-1.
  - SWL-style (a=1, size 3) fills offsets 1..3.
- RESET asserted in BUSY aborts the access: no array write, no mem_ack, state IDLE next cycle.
- RESET in DONE suppresses nothing already written.

Optional Feature:
- Macro: DMEM_POSTED_WRITE_EN.
- Defined:
  - A write request in IDLE commits to the array at that same edge, with the same byte-lane and size_err rules.
  - mem_stall stays 0 for the write; mem_ack and size_err pulse in the following cycle; the state remains IDLE.
  - Back-to-back writes are accepted every cycle.
  - A read issued the cycle after a posted write returns the new data.
  - Reads are unchanged.
- Undefined: writes take the IDLE/BUSY/DONE path exactly like reads.

Test Plan:
- Preload word 0x4 (addr 0x10) = 0x11223344; reset; read 0x10 with LATENCY=2 -> mem_stall high cycles 0-2, mem_ack and data_read_fDM=0x11223344 in cycle 3.
- Word at 0x20 = 0xFFFFFFFF; write addr 0x21, size 1, data 0x000000AB -> word 0xFFABFFFF, size_err=0; data_read_fDM unchanged.
- Word 0x30 = 0x00000000:
  - write addr 0x32, size 2, data 0x0000BEEF -> 0x0000BEEF.
  - then write addr 0x30, size 3, data 0x00123456 -> 0x123456EF.
- Word 0x40 = 0; write addr 0x43, size 2, data 0x0000CAFE -> word 0x000000CA, size_err pulses with mem_ack; word 0x44 unchanged.
- Write 0x50 with data 0xDEADBEEF, RESET pulsed in second BUSY cycle -> word 0x50 unchanged, no mem_ack, mem_stall=0 next cycle, data_read_fDM=0.
- With DMEM_POSTED_WRITE_EN: write 0x60=0x12345678 in cycle n, read 0x60 in cycle n+1 -> no stall in cycle n, read returns 0x12345678 after LATENCY+1 stall cycles.
